// File: rtl/fix_toe_responder_if.sv
// fix_toe_responder_if
// Groups the FIX engine <-> TOE responder signals into one bundle.
//   master modport : the FIX engine side (drives requests and outgoing bytes,
//                    observes session state and echoed bytes)
//   slave modport  : the responder side (fix_toe_responder)
// Signals:
//   connect_req_i / connect_addr_i               connection request and host address
//   disconnect_i / disconnect_host_num_i         disconnect request and target host
//   send_message_valid_i / message_i             outgoing FIX byte stream
//   connected_o / connected_host_addr_o          session state
//   new_message_o / message_o / valid_o          echoed message stream
//   overflow_o / checksum_err_o                  drop indications (one-cycle pulses)
interface fix_toe_responder_if;
    logic       connect_req_i;
    logic [1:0] connect_addr_i;
    logic       disconnect_i;
    logic [1:0] disconnect_host_num_i;
    logic       send_message_valid_i;
    logic [7:0] message_i;
    logic       connected_o;
    logic [1:0] connected_host_addr_o;
    logic       new_message_o;
    logic [7:0] message_o;
    logic       valid_o;
    logic       overflow_o;
    logic       checksum_err_o;

    modport master (
        output connect_req_i, connect_addr_i, disconnect_i, disconnect_host_num_i,
        output send_message_valid_i, message_i,
        input  connected_o, connected_host_addr_o, new_message_o, message_o,
        input  valid_o, overflow_o, checksum_err_o
    );

    modport slave (
        input  connect_req_i, connect_addr_i, disconnect_i, disconnect_host_num_i,
        input  send_message_valid_i, message_i,
        output connected_o, connected_host_addr_o, new_message_o, message_o,
        output valid_o, overflow_o, checksum_err_o
    );
endinterface

// File: rtl/fix_toe_responder.sv
// fix_toe_responder
// Emulates the TCP offload engine side of a FIX session: accepts a connection
// after CONNECT_DELAY cycles, buffers outgoing FIX messages, and echoes every
// complete message back byte by byte. Messages that do not fit in the DEPTH
// byte buffer are dropped whole (overflow_o pulse).
// Optional feature: define FIX_TOE_CHECKSUM_CHECK_EN to verify the FIX "10="
// checksum trailer; a mismatching message is dropped and checksum_err_o pulses.
// Without the macro every framed message is echoed and checksum_err_o is 0.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  fix_toe_responder_if.slave (see the interface file for signal list)
module fix_toe_responder #(
    parameter int CONNECT_DELAY = 4,
    parameter int DEPTH         = 256
) (
    input logic               clk,
    input logic               rst,
    fix_toe_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);
    localparam logic [7:0]    SOH       = 8'h01;

    typedef enum logic [1:0] {ST_DISC, ST_WAIT, ST_CONN} conn_state_t;
    typedef enum logic [2:0] {TR_NONE, TR_SOH, TR_1, TR_10, TR_EQ, TR_D1, TR_D2, TR_D3} trail_t;
    typedef enum logic [1:0] {RP_IDLE, RP_PULSE, RP_SEND} replay_t;

    conn_state_t   state, next_state;
    logic [7:0]    wait_cnt;
    logic [1:0]    host_addr;
    logic          flush;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, snap_ptr;
    logic [PW-1:0] fill;
    logic          full, accept, eom, mem_we, discard, overflow_q, cks_ok;
    logic          is_digit;
    logic [7:0]    digit;
    trail_t        trail, trail_next;
    replay_t       rp_state, rp_next;
    logic [7:0]    rdata;

    // Connection state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_DISC;
        else     state <= next_state;
    end

    // Connection next-state: a new request only counts from DISC, a disconnect
    // in WAIT aborts regardless of host, in CONN it must name the session host.
    always_comb begin
        next_state = state;
        case (state)
            ST_DISC: if (bus.connect_req_i) next_state = ST_WAIT;
            ST_WAIT: begin
                if (bus.disconnect_i)                           next_state = ST_DISC;
                else if (wait_cnt == 8'(CONNECT_DELAY - 1))     next_state = ST_CONN;
            end
            ST_CONN: begin
                if (bus.disconnect_i && (bus.disconnect_host_num_i == host_addr))
                    next_state = ST_DISC;
            end
            default: next_state = ST_DISC;
        endcase
    end

    // Connection outputs are a pure decode of the state.
    always_comb begin
        bus.connected_o           = (state == ST_CONN);
        bus.connected_host_addr_o = (state == ST_CONN) ? host_addr : 2'b00;
    end

    // Any cycle heading into DISC wipes the buffer, parser and replay so that
    // nothing from the old session leaks into the next one.
    assign flush = rst || (next_state == ST_DISC);

    // Connect delay counter and host address latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= 8'd0;
            host_addr <= 2'b00;
        end else if ((state == ST_DISC) && bus.connect_req_i) begin
            wait_cnt  <= 8'd0;
            host_addr <= bus.connect_addr_i;
        end else if (state == ST_WAIT) begin
            wait_cnt  <= wait_cnt + 8'd1;
        end
    end

    assign fill     = wr_ptr - rd_ptr;
    assign full     = (fill == PTR_DEPTH);
    assign accept   = (state == ST_CONN) && bus.send_message_valid_i && !flush;
    assign eom      = accept && (trail == TR_D3) && (bus.message_i == SOH);
    assign mem_we   = accept && !discard && !full;
    assign is_digit = (bus.message_i >= 8'h30) && (bus.message_i <= 8'h39);
    assign digit    = bus.message_i - 8'h30;

    // Trailer matcher: tracks progress through SOH '1' '0' '=' d d d; the SOH
    // after the third digit is the end of the message.
    always_comb begin
        trail_next = TR_NONE;
        if (bus.message_i == SOH) begin
            trail_next = TR_SOH;
        end else begin
            case (trail)
                TR_SOH:  if (bus.message_i == 8'h31) trail_next = TR_1;
                TR_1:    if (bus.message_i == 8'h30) trail_next = TR_10;
                TR_10:   if (bus.message_i == 8'h3D) trail_next = TR_EQ;
                TR_EQ:   if (is_digit) trail_next = TR_D1;
                TR_D1:   if (is_digit) trail_next = TR_D2;
                TR_D2:   if (is_digit) trail_next = TR_D3;
                default: trail_next = TR_NONE;
            endcase
        end
    end

    // Buffer storage; only uncommitted slots are written, so a write never
    // collides with a replay read of the same slot.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr[AW-1:0]] <= bus.message_i;
    end

    // Receive side: bytes are stored as they arrive, the commit pointer moves
    // only at a good end of message. A full buffer rewinds to the last commit
    // and the rest of that message is swallowed up to its end SOH.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            trail      <= TR_NONE;
            discard    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (accept) begin
                trail <= eom ? TR_NONE : trail_next;
                if (discard) begin
                    if (eom) discard <= 1'b0;
                end else if (full) begin
                    overflow_q <= 1'b1;
                    wr_ptr     <= commit_ptr;
                    discard    <= !eom;
                end else if (eom && !cks_ok) begin
                    wr_ptr     <= commit_ptr;
                end else begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    if (eom) commit_ptr <= wr_ptr + PTR_ONE;
                end
            end
        end
    end

    assign bus.overflow_o = overflow_q;

`ifdef FIX_TOE_CHECKSUM_CHECK_EN
    logic [7:0] sum_all;
    logic [7:0] sum_tag;
    logic [9:0] digit_val;
    logic       cks_err_q;

    // Checksum tracking: running byte sum, snapshotted when the '1' of a
    // candidate trailer arrives; the three trailer digits are folded into a
    // decimal value for comparison at end of message.
    always_ff @(posedge clk) begin
        if (flush) begin
            sum_all   <= 8'd0;
            sum_tag   <= 8'd0;
            digit_val <= 10'd0;
            cks_err_q <= 1'b0;
        end else begin
            cks_err_q <= eom && !discard && !full && !cks_ok;
            if (accept) begin
                sum_all <= eom ? 8'd0 : sum_all + bus.message_i;
                if ((trail == TR_SOH) && (bus.message_i == 8'h31)) sum_tag <= sum_all;
                if (trail == TR_EQ)
                    digit_val <= {2'b00, digit};
                else if ((trail == TR_D1) || (trail == TR_D2))
                    digit_val <= 10'(digit_val * 10) + {2'b00, digit};
            end
        end
    end

    assign cks_ok             = (digit_val == {2'b00, sum_tag});
    assign bus.checksum_err_o = cks_err_q;
`else
    assign cks_ok             = 1'b1;
    assign bus.checksum_err_o = 1'b0;
`endif

    // Replay state register.
    always_ff @(posedge clk) begin
        if (flush) rp_state <= RP_IDLE;
        else       rp_state <= rp_next;
    end

    // Replay next-state: announce, then stream until the snapshotted commit
    // point; the last byte is on the output when rd_ptr reaches the snapshot.
    always_comb begin
        rp_next = rp_state;
        case (rp_state)
            RP_IDLE:  if (commit_ptr != rd_ptr) rp_next = RP_PULSE;
            RP_PULSE: rp_next = RP_SEND;
            RP_SEND:  if (rd_ptr == snap_ptr) rp_next = RP_IDLE;
            default:  rp_next = RP_IDLE;
        endcase
    end

    // Replay outputs decoded from the replay state and prefetched byte.
    always_comb begin
        bus.new_message_o = (rp_state == RP_PULSE);
        bus.valid_o       = (rp_state == RP_SEND);
        bus.message_o     = (rp_state == RP_SEND) ? rdata : 8'h00;
    end

    // Replay read side: the pulse cycle prefetches the first byte, each send
    // cycle fetches the next one until the snapshot is reached.
    always_ff @(posedge clk) begin
        if (flush) begin
            rd_ptr   <= '0;
            snap_ptr <= '0;
            rdata    <= 8'h00;
        end else begin
            if ((rp_state == RP_IDLE) && (commit_ptr != rd_ptr)) snap_ptr <= commit_ptr;
            if ((rp_state == RP_PULSE) || ((rp_state == RP_SEND) && (rd_ptr != snap_ptr))) begin
                rdata  <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

// File: tb/tb_fix_toe_responder.sv
// tb_fix_toe_responder
// Directed bench for fix_toe_responder. Two instances share one stimulus:
// dut_a (DEPTH 256) covers connect, echo, checksum and disconnect behaviour,
// dut_b (DEPTH 16) covers buffer overflow. Honours FIX_TOE_CHECKSUM_CHECK_EN.
module tb_fix_toe_responder;
    localparam logic [7:0] SOH = 8'h01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       connect_req = 1'b0;
    logic [1:0] connect_addr = 2'b00;
    logic       disconnect = 1'b0;
    logic [1:0] disc_host = 2'b00;
    logic       send_valid = 1'b0;
    logic [7:0] msg_byte = 8'h00;

    int total = 0;
    int bad = 0;

    logic [7:0] tx_q[$];
    logic [7:0] cap_a[$];
    logic [7:0] cap_b[$];
    int pulse_a = 0, ovf_a = 0, cks_a = 0, gap_a = 0;
    int pulse_b = 0, ovf_b = 0, gap_b = 0;
    logic prev_v_a = 1'b0, prev_n_a = 1'b0, prev_v_b = 1'b0, prev_n_b = 1'b0;
    int ovf_at_b = 0;

    always #5 clk = ~clk;

    fix_toe_responder_if bus_a ();
    fix_toe_responder_if bus_b ();

    assign bus_a.connect_req_i         = connect_req;
    assign bus_a.connect_addr_i        = connect_addr;
    assign bus_a.disconnect_i          = disconnect;
    assign bus_a.disconnect_host_num_i = disc_host;
    assign bus_a.send_message_valid_i  = send_valid;
    assign bus_a.message_i             = msg_byte;
    assign bus_b.connect_req_i         = connect_req;
    assign bus_b.connect_addr_i        = connect_addr;
    assign bus_b.disconnect_i          = disconnect;
    assign bus_b.disconnect_host_num_i = disc_host;
    assign bus_b.send_message_valid_i  = send_valid;
    assign bus_b.message_i             = msg_byte;

    fix_toe_responder #(.CONNECT_DELAY(4), .DEPTH(256)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    fix_toe_responder #(.CONNECT_DELAY(4), .DEPTH(16))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Output monitor on the falling edge: captures echoed bytes, counts pulses,
    // and flags a break in the pulse-then-consecutive-bytes pattern.
    always @(negedge clk) begin
        if (bus_a.valid_o) cap_a.push_back(bus_a.message_o);
        if (bus_b.valid_o) cap_b.push_back(bus_b.message_o);
        if (bus_a.new_message_o)  pulse_a <= pulse_a + 1;
        if (bus_b.new_message_o)  pulse_b <= pulse_b + 1;
        if (bus_a.overflow_o)     ovf_a <= ovf_a + 1;
        if (bus_b.overflow_o)     ovf_b <= ovf_b + 1;
        if (bus_a.checksum_err_o) cks_a <= cks_a + 1;
        if ((bus_a.valid_o && !prev_v_a && !prev_n_a) || (prev_n_a && !bus_a.valid_o)) gap_a <= gap_a + 1;
        if ((bus_b.valid_o && !prev_v_b && !prev_n_b) || (prev_n_b && !bus_b.valid_o)) gap_b <= gap_b + 1;
        prev_v_a <= bus_a.valid_o;
        prev_n_a <= bus_a.new_message_o;
        prev_v_b <= bus_b.valid_o;
        prev_n_b <= bus_b.new_message_o;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Builds a framed message into tx_q: prefix ('|' = SOH), then "10=" with
    // either the correct checksum or "000", then the closing SOH.
    task automatic build_message(input string prefix, input bit good_cks);
        int sum;
        int v;
        logic [7:0] c;
        tx_q.delete();
        sum = 0;
        for (int i = 0; i < prefix.len(); i++) begin
            c = prefix[i];
            if (c == 8'h7C) c = SOH;
            tx_q.push_back(c);
            sum += c;
        end
        v = good_cks ? (sum % 256) : 0;
        tx_q.push_back(8'h31);
        tx_q.push_back(8'h30);
        tx_q.push_back(8'h3D);
        tx_q.push_back(8'(8'h30 + v / 100));
        tx_q.push_back(8'(8'h30 + (v / 10) % 10));
        tx_q.push_back(8'(8'h30 + v % 10));
        tx_q.push_back(SOH);
    endtask

    // Streams tx_q back to back; notes which byte (1-based) dut_b flagged.
    task automatic apply_stimulus();
        ovf_at_b = 0;
        for (int i = 0; i < tx_q.size(); i++) begin
            send_valid = 1'b1;
            msg_byte   = tx_q[i];
            tick(1);
            if (bus_b.overflow_o && (ovf_at_b == 0)) ovf_at_b = i + 1;
        end
        send_valid = 1'b0;
        msg_byte   = 8'h00;
    endtask

    task automatic connect_host(input logic [1:0] addr);
        connect_req  = 1'b1;
        connect_addr = addr;
        tick(1);
        connect_req  = 1'b0;
        tick(5);
    endtask

    task automatic check_zero_a(input string tag);
        check_output({tag, "_conn"},  bus_a.connected_o, 0);
        check_output({tag, "_addr"},  bus_a.connected_host_addr_o, 0);
        check_output({tag, "_newm"},  bus_a.new_message_o, 0);
        check_output({tag, "_msg"},   bus_a.message_o, 0);
        check_output({tag, "_valid"}, bus_a.valid_o, 0);
        check_output({tag, "_ovf"},   bus_a.overflow_o, 0);
        check_output({tag, "_cks"},   bus_a.checksum_err_o, 0);
    endtask

    // Waits (bounded) for tx_q.size() echoed bytes past base, then compares.
    task automatic check_echo(input string tag, input bit on_b, input int base);
        int got;
        int mism;
        for (int c = 0; c < 200; c++) begin
            got = (on_b ? cap_b.size() : cap_a.size()) - base;
            if (got >= tx_q.size()) break;
            tick(1);
        end
        tick(5);
        got = (on_b ? cap_b.size() : cap_a.size()) - base;
        check_output({tag, "_len"}, got, tx_q.size());
        mism = 0;
        for (int i = 0; (i < tx_q.size()) && (i < got); i++) begin
            if ((on_b ? cap_b[base + i] : cap_a[base + i]) !== tx_q[i]) mism++;
        end
        check_output({tag, "_data"}, mism, 0);
    endtask

    initial begin
        int base, p0, g0, o0, k0, n0;

        // Reset for 10 cycles; every output must read zero.
        tick(10);
        check_zero_a("reset");
        rst = 1'b0;
        tick(1);

        // Connect to host 00: accepted at the first edge, CONN 4 edges later.
        connect_req  = 1'b1;
        connect_addr = 2'b00;
        tick(1);
        connect_req  = 1'b0;
        check_output("wait0_conn", bus_a.connected_o, 0);
        tick(3);
        check_output("wait3_conn", bus_a.connected_o, 0);
        tick(1);
        check_output("conn_conn", bus_a.connected_o, 1);
        check_output("conn_addr", bus_a.connected_host_addr_o, 2'b00);

        // A second request while connected must not change the session.
        connect_req  = 1'b1;
        connect_addr = 2'b11;
        tick(1);
        connect_req  = 1'b0;
        check_output("rereq_addr", bus_a.connected_host_addr_o, 2'b00);
        check_output("rereq_conn", bus_a.connected_o, 1);

        // Good message: checksum 161, echoed identically and back to back.
        build_message("8=FIX.4.2|9=5|35=0|", 1'b1);
        check_output("msg1_cksum_digits", {tx_q[22], tx_q[23], tx_q[24]}, 24'h313631);
        base = cap_a.size(); p0 = pulse_a; g0 = gap_a; o0 = ovf_a; k0 = cks_a;
        apply_stimulus();
        check_output("msg1_no_early_pulse", bus_a.new_message_o, 0);
        check_echo("msg1", 1'b0, base);
        check_output("msg1_pulses", pulse_a - p0, 1);
        check_output("msg1_gaps", gap_a - g0, 0);
        check_output("msg1_ovf", ovf_a - o0, 0);
        check_output("msg1_cks", cks_a - k0, 0);

        // Same message with checksum "000".
        build_message("8=FIX.4.2|9=5|35=0|", 1'b0);
        base = cap_a.size(); p0 = pulse_a; k0 = cks_a;
        apply_stimulus();
`ifdef FIX_TOE_CHECKSUM_CHECK_EN
        check_output("badck_pulse_now", bus_a.checksum_err_o, 1);
        tick(60);
        check_output("badck_err_count", cks_a - k0, 1);
        check_output("badck_no_echo", cap_a.size() - base, 0);
        check_output("badck_no_pulse", pulse_a - p0, 0);
`else
        check_output("badck_pulse_now", bus_a.checksum_err_o, 0);
        check_echo("badck", 1'b0, base);
        check_output("badck_err_count", cks_a - k0, 0);
`endif

        // Disconnect naming the wrong host is ignored.
        disconnect = 1'b1;
        disc_host  = 2'b01;
        tick(1);
        disconnect = 1'b0;
        check_output("wrong_host_conn", bus_a.connected_o, 1);

        // Disconnect the right host mid-replay: session and stream stop at once.
        build_message("8=FIX.4.2|9=5|35=1|", 1'b1);
        apply_stimulus();
        for (int c = 0; c < 100; c++) begin
            if (bus_a.valid_o) break;
            tick(1);
        end
        check_output("replay_started", bus_a.valid_o, 1);
        disconnect = 1'b1;
        disc_host  = 2'b00;
        tick(1);
        disconnect = 1'b0;
        check_output("disc_conn", bus_a.connected_o, 0);
        check_output("disc_valid", bus_a.valid_o, 0);
        n0 = cap_a.size();
        tick(10);
        check_output("disc_no_more_bytes", cap_a.size() - n0, 0);

        // Overflow on the 16-byte instance: 20-byte message drops at byte 17.
        connect_host(2'b00);
        check_output("b_reconn", bus_b.connected_o, 1);
        build_message("8=FIXT.1|9=5|", 1'b1);
        check_output("ovf_msg_len", tx_q.size(), 20);
        base = cap_b.size(); p0 = pulse_b; o0 = ovf_b;
        apply_stimulus();
        check_output("ovf_at_byte", ovf_at_b, 17);
        tick(40);
        check_output("ovf_count", ovf_b - o0, 1);
        check_output("ovf_no_echo", cap_b.size() - base, 0);
        check_output("ovf_no_pulse", pulse_b - p0, 0);

        // A following 10-byte message fits and is echoed.
        build_message("9=|", 1'b1);
        base = cap_b.size(); g0 = gap_b;
        apply_stimulus();
        check_echo("short", 1'b1, base);
        check_output("short_gaps", gap_b - g0, 0);
        tick(60);

        // Reset in the middle of a message.
        build_message("8=FIX.4.2|9=5|35=2|", 1'b1);
        for (int i = 0; i < 6; i++) begin
            send_valid = 1'b1;
            msg_byte   = tx_q[i];
            tick(1);
        end
        send_valid = 1'b0;
        msg_byte   = 8'h00;
        rst = 1'b1;
        tick(1);
        check_zero_a("midrst");
        rst = 1'b0;
        n0 = cap_a.size();
        tick(20);
        check_output("midrst_no_echo", cap_a.size() - n0, 0);

        // Reconnect on host 10 and echo a fresh message.
        connect_host(2'b10);
        check_output("reconn_addr", bus_a.connected_host_addr_o, 2'b10);
        build_message("8=FIX.4.4|35=A|", 1'b1);
        base = cap_a.size();
        apply_stimulus();
        check_echo("fresh", 1'b0, base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
